// File: rtl/window_pkg.sv
`default_nettype none
// window_pkg: state encoding and geometry helpers shared by the window streamer and simpleCNN benches.
package window_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_PRESENT = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  // Window origins along one axis; a zero stride is treated as 1 so the bad-parameter check can still elaborate.
  function automatic int num_pos(input int img, input int k, input int stride);
    return (img - k) / ((stride > 0) ? stride : 1) + 1;
  endfunction

  function automatic int num_rows(input int img_h, input int k, input int stride);
    return num_pos(img_h, k, stride);
  endfunction

  function automatic int num_cols(input int img_w, input int k, input int stride);
    return num_pos(img_w, k, stride);
  endfunction

  // LSB of pixel (i,j) in the packed IMGIN word.
  function automatic int imgin_lsb(input int i, input int j, input int k, input int pix_w);
    return (i * k + j) * pix_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_addr_gen.sv
`default_nettype none
// window_addr_gen: window origin / in-window pixel counters and pixel-memory address for the window streamer.
module window_addr_gen
  import window_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 17,
  parameter int XW     = 5,
  parameter int YW     = 5,
  parameter int PW     = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic              step,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PW-1:0]     pix_idx,
  output logic              pix_last,
  output logic [XW-1:0]     win_x,
  output logic [YW-1:0]     win_y,
  output logic              win_last
);

  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam int NX     = num_rows(IMG_H, K, STRIDE);
  localparam int NY     = num_cols(IMG_W, K, STRIDE);
  localparam int X_LAST = (NX - 1) * STRIDE;
  localparam int Y_LAST = (NY - 1) * STRIDE;
  localparam int Y_MAX  = IMG_W - K;

  logic [ADDR_W-1:0] base;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [KW-1:0]     i;
  logic [KW-1:0]     j;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      base <= '0;
      x    <= '0;
      y    <= '0;
      i    <= '0;
      j    <= '0;
    end else if (load) begin
      base <= base_addr;
      x    <= '0;
      y    <= '0;
      i    <= '0;
      j    <= '0;
    end else begin
      // i/j wrap to 0 on the final pixel so the next window starts clean.
      if (step) begin
        if (j == KW'(K - 1)) begin
          j <= '0;
          i <= (i == KW'(K - 1)) ? '0 : i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end
      if (advance) begin
        if (int'(y) + STRIDE > Y_MAX) begin
          y <= '0;
          x <= x + XW'(STRIDE);
        end else begin
          y <= y + YW'(STRIDE);
        end
      end
    end
  end

  assign row      = ADDR_W'(x) + ADDR_W'(i);
  assign col      = ADDR_W'(y) + ADDR_W'(j);
  assign mem_addr = base + row * ADDR_W'(IMG_W) + col;
  assign pix_idx  = PW'(i) * PW'(K) + PW'(j);
  assign pix_last = (i == KW'(K - 1)) && (j == KW'(K - 1));
  assign win_x    = x;
  assign win_y    = y;
  assign win_last = (x == XW'(X_LAST)) && (y == YW'(Y_LAST));

endmodule
`default_nettype wire

// File: rtl/window_streamer.sv
`default_nettype none
// window_streamer: scans a KxK window over an image in pixel memory and streams IMGIN-packed windows.
module window_streamer
  import window_pkg::*;
#(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 5,
  parameter int STRIDE  = 1,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 17,
  parameter int COORD_W = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [ADDR_W-1:0]    BASE_ADDR,
  output logic                 MEM_RD,
  output logic [ADDR_W-1:0]    MEM_ADDR,
  input  logic [PIX_W-1:0]     MEM_DATA,
  output logic [K*K*PIX_W-1:0] WIN,
  output logic [COORD_W-1:0]   WIN_X,
  output logic [COORD_W-1:0]   WIN_Y,
  output logic                 WIN_VALID,
  input  logic                 WIN_READY,
  output logic                 WIN_LAST,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int NX = num_rows(IMG_H, K, STRIDE);
  localparam int NY = num_cols(IMG_W, K, STRIDE);
  localparam int XW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int YW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int PW = (K * K > 1) ? $clog2(K * K) : 1;

  generate
    if (K > IMG_W || K > IMG_H || STRIDE == 0 ||
        NX - 1 >= (1 << COORD_W) || NY - 1 >= (1 << COORD_W)) begin : g_param_check
      $error("window_streamer: illegal K/STRIDE/COORD_W for the image size");
    end
  endgenerate

  state_t        state;
  logic          wr_en;
  logic [PW-1:0] wr_slot;
  logic          load;
  logic          step;
  logic          advance;
  logic [PW-1:0] pix_idx;
  logic          pix_last;
  logic [XW-1:0] gen_x;
  logic [YW-1:0] gen_y;
  logic          gen_last;

  assign load    = (state == ST_IDLE) && START;
  assign step    = (state == ST_FETCH);
  assign advance = WIN_VALID && WIN_READY && !gen_last;

  window_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .STRIDE(STRIDE),
    .ADDR_W(ADDR_W),
    .XW    (XW),
    .YW    (YW),
    .PW    (PW)
  ) u_addr_gen (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .step     (step),
    .advance  (advance),
    .base_addr(BASE_ADDR),
    .mem_addr (MEM_ADDR),
    .pix_idx  (pix_idx),
    .pix_last (pix_last),
    .win_x    (gen_x),
    .win_y    (gen_y),
    .win_last (gen_last)
  );

  assign WIN_X    = COORD_W'(gen_x);
  assign WIN_Y    = COORD_W'(gen_y);
  assign WIN_LAST = WIN_VALID && gen_last;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      MEM_RD    <= 1'b0;
      WIN_VALID <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      wr_en     <= 1'b0;
      wr_slot   <= '0;
      WIN       <= '0;
    end else begin
      // Read data lags the strobe by one cycle, so the slot index is delayed to match.
      wr_en   <= (state == ST_FETCH);
      wr_slot <= pix_idx;
      if (wr_en) begin
        WIN[int'(wr_slot) * PIX_W +: PIX_W] <= MEM_DATA;
      end
      case (state)
        ST_IDLE: begin
          if (START) begin
            state  <= ST_FETCH;
            MEM_RD <= 1'b1;
            BUSY   <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (pix_last) begin
            state  <= ST_DRAIN;
            MEM_RD <= 1'b0;
          end
        end
        ST_DRAIN: begin
          state     <= ST_PRESENT;
          WIN_VALID <= 1'b1;
        end
        ST_PRESENT: begin
          if (WIN_READY) begin
            WIN_VALID <= 1'b0;
            if (gen_last) begin
              state <= ST_FINISH;
              DONE  <= 1'b1;
            end else begin
              state  <= ST_FETCH;
              MEM_RD <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_streamer.sv
`default_nettype none
// tb_window_streamer: directed self-checking bench; memory word at address a returns a[7:0].
module tb_window_streamer;
  import window_pkg::*;

  localparam int K       = 5;
  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 17;
  localparam int COORD_W = 5;
  localparam int WW      = K * K * PIX_W;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic               start, rd, valid, ready, last, busy, done;
  logic [ADDR_W-1:0]  base, addr;
  logic [PIX_W-1:0]   mdata;
  logic [WW-1:0]      win;
  logic [COORD_W-1:0] wx, wy;

  logic               s_start, s_rd, s_valid, s_ready, s_last, s_busy, s_done;
  logic [ADDR_W-1:0]  s_base, s_addr;
  logic [PIX_W-1:0]   s_mdata;
  logic [WW-1:0]      s_win;
  logic [COORD_W-1:0] s_wx, s_wy;

  window_streamer #(.STRIDE(1)) u_dut (
    .CLK(CLK), .RST(RST), .START(start), .BASE_ADDR(base),
    .MEM_RD(rd), .MEM_ADDR(addr), .MEM_DATA(mdata),
    .WIN(win), .WIN_X(wx), .WIN_Y(wy), .WIN_VALID(valid), .WIN_READY(ready),
    .WIN_LAST(last), .BUSY(busy), .DONE(done)
  );

  window_streamer #(.STRIDE(2)) u_s2 (
    .CLK(CLK), .RST(RST), .START(s_start), .BASE_ADDR(s_base),
    .MEM_RD(s_rd), .MEM_ADDR(s_addr), .MEM_DATA(s_mdata),
    .WIN(s_win), .WIN_X(s_wx), .WIN_Y(s_wy), .WIN_VALID(s_valid), .WIN_READY(s_ready),
    .WIN_LAST(s_last), .BUSY(s_busy), .DONE(s_done)
  );

  always @(posedge CLK) if (rd)   mdata   <= addr[7:0];
  always @(posedge CLK) if (s_rd) s_mdata <= s_addr[7:0];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [7:0] pix(input logic [WW-1:0] w, input int i, input int j);
    return w[imgin_lsb(i, j, K, PIX_W) +: PIX_W];
  endfunction

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid && cyc < 200) begin
      @(negedge CLK);
      cyc++;
    end
    check("valid_seen", valid, 1);
  endtask

  initial begin
    int cyc, n, ex, ey, order_bad, last_cnt, ln, lx, ly, lpix, done_cnt, stall_bad;
    logic [WW-1:0] w0;
    start = 0; base = '0; ready = 1;
    s_start = 0; s_base = '0; s_ready = 1;

    repeat (2) @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_rd", rd, 0);
    check("rst_addr", addr, 0);
    check("rst_done", done, 0);
    check("rst_win_zero", (win == '0), 1);
    check("rst_coord", {wx, wy}, 0);
    RST = 0;
    @(negedge CLK);

    // Full scan, base 0, consumer always ready
    start = 1; base = 0;
    @(negedge CLK);
    start = 0;
    check("first_rd", rd, 1);
    wait_valid(cyc);
    check("valid_latency", cyc, 26);
    check("w0_x", wx, 0);
    check("w0_y", wy, 0);
    check("w0_p00", pix(win, 0, 0), 8'h00);
    check("w0_p04", pix(win, 0, 4), 8'h04);
    check("w0_p44", pix(win, 4, 4), 8'h74);
    n = 0; ex = 0; ey = 0; order_bad = 0; last_cnt = 0; ln = -1;
    lx = -1; ly = -1; lpix = -1; done_cnt = 0; cyc = 0;
    while (n < 576 && cyc < 20000) begin
      if (done) done_cnt++;
      if (valid) begin
        if (wx != ex || wy != ey) order_bad++;
        if (last) begin
          last_cnt++; ln = n; lx = wx; ly = wy; lpix = pix(win, 0, 0);
        end
        n++;
        ey++;
        if (ey > 23) begin ey = 0; ex++; end
      end
      @(negedge CLK);
      cyc++;
    end
    check("scan_count", n, 576);
    check("scan_order", order_bad, 0);
    check("last_count", last_cnt, 1);
    check("last_index", ln, 575);
    check("last_x", lx, 23);
    check("last_y", ly, 23);
    check("last_p00", lpix, 8'h9B);
    check("done_early", done_cnt, 0);
    check("done_pulse", done, 1);
    @(negedge CLK);
    check("done_single", done, 0);
    check("busy_after", busy, 0);

    // Second image at 784; BASE_ADDR moves after START; consumer stalls
    start = 1; base = 784; ready = 0;
    @(negedge CLK);
    start = 0; base = 0;
    wait_valid(cyc);
    check("b784_p00", pix(win, 0, 0), 8'h10);
    check("b784_p44", pix(win, 4, 4), 8'h84);
    w0 = win; stall_bad = 0;
    start = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (!valid || win !== w0 || wx != 0 || wy != 0 || rd) stall_bad++;
    end
    check("stall_hold", stall_bad, 0);
    start = 0; ready = 1;
    @(negedge CLK);
    check("rd_after_stall", rd, 1);
    wait_valid(cyc);
    check("next_latency", cyc, 26);
    check("next_x", wx, 0);
    check("next_y", wy, 1);
    check("next_p00", pix(win, 0, 0), 8'h11);
    check("next_p44", pix(win, 4, 4), 8'h85);

    // Asynchronous reset mid-FETCH
    repeat (6) @(negedge CLK);
    #2 RST = 1;
    #1;
    check("arst_rd", rd, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", addr, 0);
    check("arst_valid", valid, 0);
    check("arst_win_zero", (win == '0), 1);
    @(negedge CLK);
    RST = 0;
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (done || busy) done_cnt++;
    end
    check("arst_quiet", done_cnt, 0);
    start = 1; base = 0;
    @(negedge CLK);
    start = 0;
    wait_valid(cyc);
    check("rs_x", wx, 0);
    check("rs_y", wy, 0);
    check("rs_p12", pix(win, 1, 2), 8'h1E);
    check("rs_p30", pix(win, 3, 0), 8'h54);
    check("rs_p44", pix(win, 4, 4), 8'h74);

    // Stride 2 instance
    s_start = 1; s_base = 0;
    @(negedge CLK);
    s_start = 0;
    n = 0; ex = 0; ey = 0; order_bad = 0; last_cnt = 0; ln = -1;
    lx = -1; ly = -1; lpix = -1; done_cnt = 0; cyc = 0;
    while (n < 144 && cyc < 10000) begin
      if (s_done) done_cnt++;
      if (s_valid) begin
        if (s_wx != ex || s_wy != ey) order_bad++;
        if (s_last) begin
          last_cnt++; ln = n; lx = s_wx; ly = s_wy; lpix = pix(s_win, 0, 0);
        end
        n++;
        ey += 2;
        if (ey > 23) begin ey = 0; ex += 2; end
      end
      @(negedge CLK);
      cyc++;
    end
    check("s2_count", n, 144);
    check("s2_order", order_bad, 0);
    check("s2_last_count", last_cnt, 1);
    check("s2_last_index", ln, 143);
    check("s2_last_x", lx, 22);
    check("s2_last_y", ly, 22);
    check("s2_last_p00", lpix, 8'h7E);
    check("s2_done_early", done_cnt, 0);
    check("s2_done", s_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
